mux_n_to_1_scan: RTL and testbench

Parametrised, registered N-to-1 channel multiplexer with two modes: manual selection, and automatic round-robin scanning with a programmable dwell time. It generalises the team's combinational 4-to-1 mux family to N channels of W bits. It adds an output register, a channel-index output and strobes, and is used wherever a single datapath must time-share several sources.

---
 rtl/mux_n_to_1_scan.sv | 119 +++++++++++
 tb/tb_mux_n_to_1_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_scan.sv
// Registered N-to-1 channel multiplexer with manual select and a round-robin
// scan mode that dwells DWELL enabled cycles on each channel.
module mux_n_to_1_scan #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     out,
    output logic [SEL_W-1:0] ch,
    output logic             valid,
    output logic             wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   ch_reg, ch_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [W-1:0]       out_reg, out_next;
    logic               valid_reg, valid_next;
    logic               wrap_reg, wrap_next;
    logic [W-1:0]       chan [N];
    logic [W-1:0]       pick_data;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = in[gi*W +: W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        cnt_next   = cnt_reg;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        if (en) begin
            if (!mode) begin
                // Any enabled edge with mode low is a manual edge, including the exit from scan.
                state_next = MANUAL;
                ch_next    = sel;
                cnt_next   = '0;
                valid_next = (sel != ch_reg);
            end else begin
                case (state_reg)
                    MANUAL: begin
                        state_next = SCAN;
                        ch_next    = '0;
                        cnt_next   = '0;
                        valid_next = 1'b1;
                    end
                    SCAN: begin
                        if (cnt_reg == CNT_W'(DWELL - 1)) begin
                            cnt_next   = '0;
                            valid_next = 1'b1;
                            if (ch_reg == SEL_W'(N - 1)) begin
                                ch_next   = '0;
                                wrap_next = 1'b1;
                            end else begin
                                ch_next = ch_reg + SEL_W'(1);
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: state_next = MANUAL;
                endcase
            end
        end
    end

    // Out-of-range channel indices fall through the loop and select zero.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_next == SEL_W'(k)) begin
                pick_data = chan[k];
            end
        end
        out_next = en ? pick_data : out_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MANUAL;
            ch_reg    <= '0;
            cnt_reg   <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign out   = out_reg;
    assign ch    = ch_reg;
    assign valid = valid_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Directed bench for mux_n_to_1_scan: one N=4/DWELL=3 instance and one
// N=3/DWELL=1 instance, checked with immediate assertions after each edge.
module tb_mux_n_to_1_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst, a_mode, a_en;
    logic [31:0] a_in;
    logic [1:0]  a_sel;
    logic [7:0]  a_out;
    logic [1:0]  a_ch;
    logic        a_valid, a_wrap;

    logic        b_rst, b_mode, b_en;
    logic [23:0] b_in;
    logic [1:0]  b_sel;
    logic [7:0]  b_out;
    logic [1:0]  b_ch;
    logic        b_valid, b_wrap;

    mux_n_to_1_scan #(.N(4), .W(8), .DWELL(3)) dut_a (
        .clk(clk), .rst(a_rst), .in(a_in), .sel(a_sel), .mode(a_mode), .en(a_en),
        .out(a_out), .ch(a_ch), .valid(a_valid), .wrap(a_wrap)
    );

    mux_n_to_1_scan #(.N(3), .W(8), .DWELL(1)) dut_b (
        .clk(clk), .rst(b_rst), .in(b_in), .sel(b_sel), .mode(b_mode), .en(b_en),
        .out(b_out), .ch(b_ch), .valid(b_valid), .wrap(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int ech, input int ev, input int ew, input int eout);
        chk({tag, ".a.out"},   32'(a_out),   32'(eout));
        chk({tag, ".a.ch"},    32'(a_ch),    32'(ech));
        chk({tag, ".a.valid"}, 32'(a_valid), 32'(ev));
        chk({tag, ".a.wrap"},  32'(a_wrap),  32'(ew));
    endtask

    task automatic chk_b(input string tag, input int ech, input int ev, input int ew, input int eout);
        chk({tag, ".b.out"},   32'(b_out),   32'(eout));
        chk({tag, ".b.ch"},    32'(b_ch),    32'(ech));
        chk({tag, ".b.valid"}, 32'(b_valid), 32'(ev));
        chk({tag, ".b.wrap"},  32'(b_wrap),  32'(ew));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int sels  [6] = '{0, 1, 2, 3, 2, 2};
    int evs   [6] = '{0, 1, 1, 1, 1, 0};
    int eouts [6] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4, 32'hC3, 32'hC3};
    int scan_out [20] = '{32'hA1, 32'h5A, 32'h5A, 32'hB2, 32'h6B, 32'h6B,
                          32'hC3, 32'hC3, 32'hC3, 32'hD4, 32'hD4, 32'hD4,
                          32'h5A, 32'h5A, 32'h5A, 32'h6B, 32'h6B, 32'h6B,
                          32'hC3, 32'hC3};

    initial begin
        a_rst = 1'b1; a_en = 1'b1; a_mode = 1'b0; a_sel = '0; a_in = '0;
        b_rst = 1'b1; b_en = 1'b1; b_mode = 1'b0; b_sel = '0; b_in = '0;

        // Reset dominates random stimulus
        repeat (2) begin
            a_in   = $urandom;
            a_sel  = 2'($urandom_range(0, 3));
            a_mode = 1'($urandom_range(0, 1));
            b_in   = 24'($urandom);
            b_sel  = 2'($urandom_range(0, 3));
            b_mode = 1'($urandom_range(0, 1));
            step();
            chk_a("reset", 0, 0, 0, 0);
            chk_b("reset", 0, 0, 0, 0);
        end

        // Manual sweep
        a_rst = 1'b0; a_mode = 1'b0; a_in = 32'hD4C3B2A1;
        for (int i = 0; i < 6; i++) begin
            a_sel = 2'(sels[i]);
            step();
            chk_a("manual", sels[i], evs[i], 0, eouts[i]);
        end

        // Scan with mid-dwell data changes on channels 0 and 1
        a_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) a_in[7:0]  = 8'h5A;
            if (i == 4) a_in[15:8] = 8'h6B;
            step();
            chk_a("scan", (i / 3) % 4, (i % 3 == 0) ? 1 : 0, (i == 12) ? 1 : 0, scan_out[i]);
        end

        // Freeze on ch=2 with counter=1
        a_en = 1'b0; a_in[23:16] = 8'hEE;
        repeat (5) begin
            step();
            chk_a("freeze", 2, 0, 0, 32'hC3);
        end
        a_en = 1'b1;
        step();
        chk_a("resume1", 2, 0, 0, 32'hEE);
        step();
        chk_a("resume2", 3, 1, 0, 32'hD4);

        // Reset mid-scan, then manual, then fresh entry and exit
        a_rst = 1'b1;
        step();
        chk_a("rstmid", 0, 0, 0, 0);
        a_rst = 1'b0; a_mode = 1'b0; a_sel = 2'd0;
        step();
        chk_a("postrst", 0, 0, 0, 32'h5A);
        a_mode = 1'b1;
        step();
        chk_a("entry", 0, 1, 0, 32'h5A);
        step();
        chk_a("dwell", 0, 0, 0, 32'h5A);
        a_mode = 1'b0; a_sel = 2'd1;
        step();
        chk_a("exit", 1, 1, 0, 32'h6B);
        a_mode = 1'b1;
        step();
        chk_a("reentry", 0, 1, 0, 32'h5A);
        step();
        chk_a("reent1", 0, 0, 0, 32'h5A);
        step();
        chk_a("reent2", 0, 0, 0, 32'h5A);
        step();
        chk_a("reent3", 1, 1, 0, 32'h6B);

        // N=3: out-of-range select, then DWELL=1 scan
        b_rst = 1'b0; b_mode = 1'b0; b_in = 24'h332211; b_sel = 2'd3;
        step();
        chk_b("oor", 3, 1, 0, 0);
        b_mode = 1'b1; b_sel = 2'd1;
        step();
        chk_b("d1.0", 0, 1, 0, 32'h11);
        step();
        chk_b("d1.1", 1, 1, 0, 32'h22);
        step();
        chk_b("d1.2", 2, 1, 0, 32'h33);
        step();
        chk_b("d1.3", 0, 1, 1, 32'h11);
        step();
        chk_b("d1.4", 1, 1, 0, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
